// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state encoding and sizing functions.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits per operation.
  function automatic int ndig(
    input int w,
    input int d
  );
    return w / d;
  endfunction

  // Digit counter width, never below one bit.
  function automatic int kbits(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operand width must split into whole digits.
  function automatic bit digits_ok(
    input int w,
    input int d
  );
    return (d > 0) && (d <= w)
        && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// One DIGIT-wide ripple adder slice, purely combinational.
// cmsb exposes the carry into the top bit for overflow detection.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  // Bit-level ripple chain across the digit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i])
               | (x[i] & c[i])
               | (y[i] & c[i]);
    end
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock.
// Subtract support is built only with SERIAL_ADDER_SUB_EN.
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int  NDIG   = ndig(WIDTH, DIGIT);
  localparam int  KW     = kbits(NDIG);
  localparam bit  CFG_OK = digits_ok(WIDTH, DIGIT);
  localparam logic [KW-1:0] KLAST =
    KW'(NDIG - 1);

  generate
    if (!CFG_OK) begin : g_cfg_bad
      $error("WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [DIGIT-1:0] dx, dy, dsum;
  logic             dco, dcmsb;

  // Operand conditioning at capture time.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (k_q == KLAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last)     state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Handshake outputs from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Select the current operand digits.
  always_comb begin
    dx = '0;
    dy = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (k_q == i[KW-1:0]) begin
        dx = a_q[i*DIGIT +: DIGIT];
        dy = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x    (dx),
    .y    (dy),
    .ci   (cy_q),
    .sum  (dsum),
    .co   (dco),
    .cmsb (dcmsb)
  );

  // Datapath next state: capture, per-digit writeback, flags.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    s_d  = s_q;
    k_d  = k_q;
    cy_d = cy_q;
    co_d = co_q;
    ov_d = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d  = a;
          b_d  = b_eff;
          cy_d = cin_eff;
          k_d  = '0;
        end
      end
      RUN: begin
        cy_d = dco;
        for (int i = 0; i < NDIG; i++) begin
          if (k_q == i[KW-1:0]) begin
            s_d[i*DIGIT +: DIGIT] = dsum;
          end
        end
        if (last) begin
          co_d = dco;
          ov_d = dcmsb ^ dco;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      k_q  <= '0;
      cy_q <= 1'b0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
      k_q  <= k_d;
      cy_q <= cy_d;
      co_q <= co_d;
      ov_q <= ov_d;
    end
  end

  assign s     = s_q;
  assign c_out = co_q;
  assign ovf   = ov_q;

endmodule
